mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, variable-latency main memory between the pipeline's instruction-fetch port and its data (load/store) port. It sits between the pipelined core's fetch/MEM stages and the memory. Fetch and MEM-stage stalls are derived from the absence of the per-port ack. It arbitrates with data priority and starvation protection, sequences the memory request/ready handshake, and enforces a watchdog timeout.

## Interface
- `ADDR_W`, 32: address width, byte addressed, word aligned.
- `DATA_W`, 32: data width.
- `TIMEOUT_CYC`, 64: maximum cycles `memReq` may wait for `memReady` before the access is aborted.
- `STARVE_LIM`, 4: consecutive data grants, with fetch pending, after which fetch wins once.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `ifReq`  in  1  fetch request, level, held until `ifAck`.
- `ifAddr`  in  ADDR_W  fetch address.
- `ifRData`  out  DATA_W  fetched instruction, valid with `ifAck`.
- `ifAck`  out  1  one-cycle completion pulse.
- `dReq`  in  1  data request, level, held until `dAck`.
- `dWe`  in  1  1 = store, 0 = load.
- `dAddr`  in  ADDR_W  data address.
- `dWData`  in  DATA_W  store data.
- `dRData`  out  DATA_W  load data, valid with `dAck`.
- `dAck`  out  1  one-cycle completion pulse.
- `memReq`  out  1  memory request, held until `memReady`.
- `memWe`  out  1  memory write enable.
- `memAddr`  out  ADDR_W  memory address.
- `memWData`  out  DATA_W  memory write data.
- `memRData`  in  DATA_W  memory read data, valid with `memReady`.
- `memReady`  in  1  one-cycle completion from memory.
- `memErr`  out  1  sticky timeout flag, cleared only by reset.

## Operation
- FSM states are `IDLE`, `IACC`, `DACC` and `DONE`.
- **IDLE, grant rule:**
  - With `dReq` only: go to `DACC`.
  - With `ifReq` only: go to `IACC`.
  - With both: `DACC`, unless the starve counter equals `STARVE_LIM`, in which case `IACC`.
- **Starve counter:**
  - Increments on each `DACC` grant while `ifReq` is high.
  - Clears on any `IACC` grant.
  - Clears on any `DACC` grant while `ifReq` is low.
  - Saturates at `STARVE_LIM`.
- **IACC/DACC:**
  - `memReq`, `memWe`, `memAddr` and `memWData` are registered and held stable, latched from the granted port at grant.
  - `memWe` is 0 in `IACC`.
  - On `memReady`: capture `memRData` into the port's rdata register and go to `DONE`.
- **Watchdog:**
  - The wait counter resets at grant and increments each cycle `memReady` is low.
  - When it reaches `TIMEOUT_CYC`: drop `memReq`, set `memErr`, force the port rdata to 0, and go to `DONE`.
- **DONE:**
  - Pulse the granted port's ack for exactly one cycle, then return to `IDLE`.
  - Requests are ignored in `DONE`. The requester deasserts or re-presents `req` in this cycle.
- Requests that change address while pending are illegal. Behaviour uses the address latched at grant.
- Reset at any point:
  - State returns to `IDLE` and all counters clear.
  - An in-flight memory access is abandoned; a late `memReady` arriving in `IDLE` is ignored.

## Timing
- Reset values: every output is 0, including `ifRData`, `dRData` and `memErr`.
- Request sampled in cycle 0 → `memReq` high in cycle 1 → `memReady` earliest in cycle 1 → ack in the cycle after `memReady`. The minimum is a 2-cycle ack latency (ack in cycle 2).
- Back-to-back: a request held through the `DONE` cycle is re-granted in the following `IDLE` cycle. Per-port throughput is therefore one access per 3 cycles at zero memory wait.
- `memReady` received while not in `IACC`/`DACC` is ignored.
- `memReady` arriving in the same cycle the wait counter reaches `TIMEOUT_CYC` counts as success; `memErr` stays 0.

## Configuration
- `MEM_ARB_FETCH_BUF_EN` defined: a one-entry fetch buffer `{valid, addr, data}` is compiled in.
  - **Fill:** the buffer is loaded on every successful `IACC` completion.
  - **Hit:** an `ifReq` whose `ifAddr` equals the valid `addr` in `IDLE` goes straight to `DONE`, with no memory access and ack 1 cycle after the request. A hit never increments the starve counter.
  - **Invalidate:** a successful or timed-out `DACC` store to the buffered address clears the entry. A timed-out `IACC` also clears it. Reset clears it.
- `MEM_ARB_FETCH_BUF_EN` undefined: there is no buffer and every fetch goes to memory.

## Structure
- Shared package `mem_arb_pkg` holds:
  - The state enum (`IDLE`, `IACC`, `DACC`, `DONE`).
  - The default `ADDR_W`/`DATA_W`.
  - The starve- and wait-counter width functions (`$clog2(STARVE_LIM+1)`, `$clog2(TIMEOUT_CYC+1)`).
- One sub-module, `arb_fetch_buf`, holds the hit compare, fill and invalidate logic. It is instantiated only under `MEM_ARB_FETCH_BUF_EN`.

## Test plan
- **Lone load.** Stimulus: `dReq=1`, `dWe=0`, `dAddr=0x40`; memory returns `0x1234` with 3 wait cycles. Required: `memReq` high for 4 cycles at address `0x40`, then `dAck` with `dRData=0x1234` the cycle after `memReady`.
- **Contention.** Stimulus: `ifReq` and `dReq` are asserted together, and `dReq` is kept re-asserted. Required: 4 `DACC` grants, then one `IACC` grant (`STARVE_LIM=4`), after which data priority resumes.
- **Timeout.** Stimulus: `memReady` is never asserted. Required: `memReq` drops after 64 cycles, `dAck` pulses with `dRData=0`, and `memErr` becomes 1 and stays 1 until `Reset`.
- **Reset mid-access.** Stimulus: `Reset` is asserted during `IACC`, then `memReady` arrives one cycle after release. Required: all outputs are 0, there is no `ifAck`, and the late `memReady` is ignored.
- **Fetch buffer (with `MEM_ARB_FETCH_BUF_EN`).** Stimulus: fetch `0x100`, then fetch `0x100` again. Required: the second `ifAck` arrives 1 cycle after `ifReq` with no `memReq`.
  - Continue with a store to `0x100`, then fetch `0x100` again: this fetch goes to memory.
- **Back-to-back stores.** Stimulus: `dWe=1`, zero-wait memory, `dReq` held high. Required: one `dAck` every 3 cycles, and each `memWData` matches the `dWData` latched at grant.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizing helpers for the fetch/data memory port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Width needed to count up to and including the starvation limit.
  function automatic int starve_cnt_w(input int starve_lim);
    return $clog2(starve_lim + 1);
  endfunction

  // Width needed to count up to and including the watchdog limit.
  function automatic int wait_cnt_w(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and memory-side handshake of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: ports stall by holding req until their one-cycle ack.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic [DATA_W-1:0] ifRData;
  logic              ifAck;
  logic              dReq;
  logic              dWe;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWData;
  logic [DATA_W-1:0] dRData;
  logic              dAck;
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;
  logic              memReady;
  logic              memErr;

  // Arbiter side.
  modport slave (
    input  ifReq, ifAddr, dReq, dWe, dAddr, dWData, memRData, memReady,
    output ifRData, ifAck, dRData, dAck, memReq, memWe, memAddr, memWData, memErr
  );

  // Core + memory side (stimulus / surrounding logic).
  modport master (
    output ifReq, ifAddr, dReq, dWe, dAddr, dWData, memRData, memReady,
    input  ifRData, ifAck, dRData, dAck, memReq, memWe, memAddr, memWData, memErr
  );
endinterface

// File: rtl/mem_port_arbiter_fetch_buf.sv
// One-entry fetch buffer {valid, addr, data}; built only with MEM_ARB_FETCH_BUF_EN.
// Latency: combinational hit/data lookup, fill/invalidate take effect next cycle.
// Backpressure: none; driven by arbiter state only.
module arb_fetch_buf
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              store_inv,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic              flush
);
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  assign hit      = valid_q && (lookup_addr == addr_q);
  assign hit_data = data_q;

  // Fill on successful fetch; drop the entry on a store to it or a failed fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (flush || (store_inv && valid_q && (store_addr == addr_q))) begin
      valid_q <= 1'b0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr;
      data_q  <= fill_data;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and data ports (data priority, anti-starve, watchdog); MEM_ARB_FETCH_BUF_EN adds a one-entry fetch buffer.
// Latency: ack 2 cycles after request at zero memory wait (1 cycle on a fetch-buffer hit).
// Backpressure: ports hold req until ack; memory side holds memReq until memReady or watchdog expiry.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 64,
  parameter int STARVE_LIM  = 4
) (
  input logic               CLK,
  input logic               Reset,
  mem_port_arbiter_if.slave bus
);
  localparam int SC_W = starve_cnt_w(STARVE_LIM);
  localparam int WC_W = wait_cnt_w(TIMEOUT_CYC);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);
  localparam logic [WC_W-1:0] WAIT_MAX   = WC_W'(TIMEOUT_CYC);

  arb_state_e        state_q, state_d;
  logic              serve_d_q;
  logic [SC_W-1:0]   starve_q;
  logic [WC_W-1:0]   wait_q;
  logic              mem_req_q, mem_we_q, mem_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
  logic              grant_i, grant_d, grant_hit, acc_ok, acc_to;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;

`ifdef MEM_ARB_FETCH_BUF_EN
  arb_fetch_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fetch_buf (
    .clk        (CLK),
    .rst        (Reset),
    .lookup_addr(bus.ifAddr),
    .hit        (buf_hit),
    .hit_data   (buf_data),
    .fill_en    (acc_ok && (state_q == IACC)),
    .fill_addr  (mem_addr_q),
    .fill_data  (bus.memRData),
    .store_inv  ((state_q == DACC) && mem_we_q && (acc_ok || acc_to)),
    .store_addr (mem_addr_q),
    .flush      (acc_to && (state_q == IACC))
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // Next state: grant in IDLE, finish access on memReady or watchdog, ack for one cycle in DONE.
  // The watchdog fires only when memReady is still low with the counter already at the limit,
  // so a memReady arriving in that cycle wins.
  always_comb begin
    state_d   = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    grant_hit = 1'b0;
    acc_ok    = 1'b0;
    acc_to    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dReq && !(bus.ifReq && (starve_q == STARVE_MAX))) begin
          grant_d = 1'b1;
          state_d = DACC;
        end else if (bus.ifReq) begin
          if (buf_hit) begin
            grant_hit = 1'b1;
            state_d   = DONE;
          end else begin
            grant_i = 1'b1;
            state_d = IACC;
          end
        end
      end
      IACC, DACC: begin
        if (bus.memReady) begin
          acc_ok  = 1'b1;
          state_d = DONE;
        end else if (wait_q == WAIT_MAX) begin
          acc_to  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Starvation counter (data wins while fetch waits) and watchdog wait counter.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      starve_q <= '0;
      wait_q   <= '0;
    end else begin
      if (grant_d) begin
        if (!bus.ifReq)                starve_q <= '0;
        else if (starve_q != STARVE_MAX) starve_q <= starve_q + 1'b1;
      end else if (grant_i || grant_hit) begin
        starve_q <= '0;
      end
      if (grant_d || grant_i) begin
        wait_q <= '0;
      end else if (((state_q == IACC) || (state_q == DACC)) && !bus.memReady &&
                   (wait_q != WAIT_MAX)) begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end

  // Memory request latched at grant and held; read data captured (or zeroed on timeout) at completion.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      serve_d_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_err_q   <= 1'b0;
    end else if (grant_d) begin
      serve_d_q   <= 1'b1;
      mem_req_q   <= 1'b1;
      mem_we_q    <= bus.dWe;
      mem_addr_q  <= bus.dAddr;
      mem_wdata_q <= bus.dWData;
    end else if (grant_i) begin
      serve_d_q   <= 1'b0;
      mem_req_q   <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= bus.ifAddr;
      mem_wdata_q <= '0;
    end else if (grant_hit) begin
      serve_d_q  <= 1'b0;
      if_rdata_q <= buf_data;
    end else if (acc_ok || acc_to) begin
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      if (serve_d_q) d_rdata_q  <= acc_ok ? bus.memRData : '0;
      else           if_rdata_q <= acc_ok ? bus.memRData : '0;
      if (acc_to) mem_err_q <= 1'b1;
    end
  end

  assign bus.ifAck    = (state_q == DONE) && !serve_d_q;
  assign bus.dAck     = (state_q == DONE) && serve_d_q;
  assign bus.ifRData  = if_rdata_q;
  assign bus.dRData   = d_rdata_q;
  assign bus.memReq   = mem_req_q;
  assign bus.memWe    = mem_we_q;
  assign bus.memAddr  = mem_addr_q;
  assign bus.memWData = mem_wdata_q;
  assign bus.memErr   = mem_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT_CYC=64, STARVE_LIM=4).
// Latency: inputs driven 1 ns after the rising edge, outputs sampled at the same point.
// Backpressure: requests held until their ack, then dropped or re-presented in the ack cycle.
module tb_mem_port_arbiter;
  logic CLK = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(64), .STARVE_LIM(4)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ifRData"},  bus.ifRData,  32'h0);
    chk({tag, "_ifAck"},    bus.ifAck,    32'h0);
    chk({tag, "_dRData"},   bus.dRData,   32'h0);
    chk({tag, "_dAck"},     bus.dAck,     32'h0);
    chk({tag, "_memReq"},   bus.memReq,   32'h0);
    chk({tag, "_memWe"},    bus.memWe,    32'h0);
    chk({tag, "_memAddr"},  bus.memAddr,  32'h0);
    chk({tag, "_memWData"}, bus.memWData, 32'h0);
    chk({tag, "_memErr"},   bus.memErr,   32'h0);
  endtask

  initial begin
    logic [5:0] fetch_pat;
    fetch_pat = 6'b010000;  // grant k is a fetch when bit k is set
    Reset = 1'b1;
    bus.ifReq = 1'b0; bus.ifAddr = '0; bus.dReq = 1'b0; bus.dWe = 1'b0;
    bus.dAddr = '0; bus.dWData = '0; bus.memRData = '0; bus.memReady = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    Reset = 1'b0;
    tick();

    // Lone load, 3 wait cycles: memReq high 4 cycles, dAck the cycle after memReady.
    bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 32'h40;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk("load_memReq", bus.memReq, 32'h1);
      chk("load_memAddr", bus.memAddr, 32'h40);
      chk("load_dAck_early", bus.dAck, 32'h0);
      if (i == 4) begin bus.memReady = 1'b1; bus.memRData = 32'h1234; end
      tick();
    end
    bus.memReady = 1'b0; bus.dReq = 1'b0;
    chk("load_dAck", bus.dAck, 32'h1);
    chk("load_dRData", bus.dRData, 32'h1234);
    chk("load_memReq_drop", bus.memReq, 32'h0);
    tick();
    chk("load_dAck_pulse", bus.dAck, 32'h0);

    // Contention with memReady held high (ignored outside IACC/DACC): D,D,D,D,I,D.
    bus.ifReq = 1'b1; bus.ifAddr = 32'h200; bus.dReq = 1'b1; bus.dAddr = 32'h300;
    bus.memReady = 1'b1; bus.memRData = 32'hAA;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("cont_memReq", bus.memReq, 32'h1);
      chk("cont_memAddr", bus.memAddr, fetch_pat[k] ? 32'h200 : 32'h300);
      tick();
      chk("cont_ifAck", bus.ifAck, {31'h0, fetch_pat[k]});
      chk("cont_dAck", bus.dAck, {31'h0, !fetch_pat[k]});
      tick();
    end
    bus.ifReq = 1'b0;

    // Back-to-back stores at zero wait: one dAck every 3 cycles, write data from grant.
    bus.dWe = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.dWData = 32'h1111_1111 * (k + 1);
      bus.dAddr  = 32'h500 + 32'(4 * k);
      tick();
      chk("st_memReq", bus.memReq, 32'h1);
      chk("st_memWe", bus.memWe, 32'h1);
      chk("st_memWData", bus.memWData, 32'h1111_1111 * (k + 1));
      chk("st_memAddr", bus.memAddr, 32'h500 + 32'(4 * k));
      tick();
      chk("st_dAck", bus.dAck, 32'h1);
      tick();
      chk("st_dAck_gap", bus.dAck, 32'h0);
    end
    bus.dReq = 1'b0; bus.dWe = 1'b0; bus.memReady = 1'b0;
    tick();

    // memReady in the cycle the wait counter reaches 64: success, no error.
    bus.dReq = 1'b1; bus.dAddr = 32'h84; bus.memRData = 32'h5A5A_5A5A;
    tick();
    for (int i = 1; i <= 65; i++) begin
      chk("edge_memReq", bus.memReq, 32'h1);
      if (i == 65) bus.memReady = 1'b1;
      tick();
    end
    bus.memReady = 1'b0; bus.dReq = 1'b0;
    chk("edge_dAck", bus.dAck, 32'h1);
    chk("edge_dRData", bus.dRData, 32'h5A5A_5A5A);
    chk("edge_memErr", bus.memErr, 32'h0);
    tick();

    // Timeout: memReq held through 64 idle wait cycles, then abort with zero data.
    bus.dReq = 1'b1; bus.dAddr = 32'h88;
    tick();
    for (int i = 1; i <= 65; i++) begin
      chk("to_memReq", bus.memReq, 32'h1);
      tick();
    end
    bus.dReq = 1'b0;
    chk("to_memReq_drop", bus.memReq, 32'h0);
    chk("to_dAck", bus.dAck, 32'h1);
    chk("to_dRData", bus.dRData, 32'h0);
    chk("to_memErr", bus.memErr, 32'h1);
    tick();
    chk("to_dAck_pulse", bus.dAck, 32'h0);

    // memErr stays set across a later successful access.
    bus.dReq = 1'b1; bus.dAddr = 32'h8C; bus.memReady = 1'b1; bus.memRData = 32'h77;
    tick(); tick();
    chk("sticky_dAck", bus.dAck, 32'h1);
    chk("sticky_dRData", bus.dRData, 32'h77);
    chk("sticky_memErr", bus.memErr, 32'h1);
    bus.dReq = 1'b0; bus.memReady = 1'b0;
    tick();

    // Reset during IACC; late memReady after release is ignored.
    bus.ifReq = 1'b1; bus.ifAddr = 32'h100;
    tick();
    chk("rm_memReq", bus.memReq, 32'h1);
    chk("rm_memWe", bus.memWe, 32'h0);
    chk("rm_memAddr", bus.memAddr, 32'h100);
    tick();
    Reset = 1'b1; bus.ifReq = 1'b0;
    #1;
    chk_all_zero("rm_async");
    tick();
    Reset = 1'b0;
    tick();
    bus.memReady = 1'b1; bus.memRData = 32'hDEAD;
    tick();
    bus.memReady = 1'b0;
    chk("rm_ifAck", bus.ifAck, 32'h0);
    chk("rm_memReq_late", bus.memReq, 32'h0);
    chk("rm_ifRData", bus.ifRData, 32'h0);
    tick();
    chk("rm_ifAck2", bus.ifAck, 32'h0);

    // Repeat fetch of the same address.
    bus.ifReq = 1'b1; bus.ifAddr = 32'h100; bus.memReady = 1'b1; bus.memRData = 32'hF00D;
    tick();
    chk("f1_memReq", bus.memReq, 32'h1);
    tick();
    chk("f1_ifAck", bus.ifAck, 32'h1);
    chk("f1_ifRData", bus.ifRData, 32'hF00D);
    bus.ifReq = 1'b0;
    tick();
    bus.ifReq = 1'b1; bus.memRData = 32'hBAD0;
    tick();
`ifdef MEM_ARB_FETCH_BUF_EN
    chk("f2_hit_ifAck", bus.ifAck, 32'h1);
    chk("f2_hit_memReq", bus.memReq, 32'h0);
    chk("f2_hit_ifRData", bus.ifRData, 32'hF00D);
    bus.ifReq = 1'b0;
    tick();
    bus.dReq = 1'b1; bus.dWe = 1'b1; bus.dAddr = 32'h100; bus.dWData = 32'h1;
    tick(); tick();
    chk("f_store_dAck", bus.dAck, 32'h1);
    bus.dReq = 1'b0; bus.dWe = 1'b0;
    tick();
    bus.ifReq = 1'b1; bus.memRData = 32'hBEEF;
    tick();
    chk("f3_memReq", bus.memReq, 32'h1);
    chk("f3_ifAck", bus.ifAck, 32'h0);
    tick();
    chk("f3_ifAck_late", bus.ifAck, 32'h1);
    chk("f3_ifRData", bus.ifRData, 32'hBEEF);
`else
    chk("f2_memReq", bus.memReq, 32'h1);
    chk("f2_ifAck", bus.ifAck, 32'h0);
    tick();
    chk("f2_ifAck_late", bus.ifAck, 32'h1);
    chk("f2_ifRData", bus.ifRData, 32'hBAD0);
`endif
    bus.ifReq = 1'b0; bus.memReady = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL sim_time_limit observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end
endmodule
